// File: rtl/wormhole_mesh_router.sv
`default_nettype none
// ============================================================================
// Module  : wormhole_mesh_router
// Brief   : 5-port 2D-mesh wormhole router with per-input FIFOs, XY/YX routing
//           and per-output round-robin packet allocation.
// Revision: 1.0
// ============================================================================
module wormhole_mesh_router #(
    parameter int FLIT_SIZE    = 18,
    parameter int BUF_DEPTH    = 4,
    parameter int NOC_WIDTH    = 4,
    parameter int NOC_LENGTH   = 4,
    parameter int ROUTER_X     = 0,
    parameter int ROUTER_Y     = 0,
    parameter int ROUTING_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5*FLIT_SIZE-1:0] in_data,
    input  logic [4:0]             in_req,
    output logic [4:0]             in_ack,
    output logic [5*FLIT_SIZE-1:0] out_data,
    output logic [4:0]             out_req,
    input  logic [4:0]             out_ack,
    output logic [4:0]             out_busy
);
    localparam int NP = 5;
    localparam int XW = (NOC_WIDTH  > 1) ? $clog2(NOC_WIDTH)  : 1;
    localparam int YW = (NOC_LENGTH > 1) ? $clog2(NOC_LENGTH) : 1;
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_EAST  = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;

    logic [FLIT_SIZE-1:0] mem_q   [NP][BUF_DEPTH];
    logic [AW-1:0]        rd_q    [NP];
    logic [AW-1:0]        wr_q    [NP];
    logic [CW-1:0]        cnt_q   [NP];
    logic [FLIT_SIZE-1:0] front   [NP];
    logic [NP-1:0]        empty;
    logic [NP-1:0]        full;
    logic [NP-1:0]        push;
    logic [NP-1:0]        pop;

    logic [NP-1:0]        lock_q;
    logic [2:0]           owner_q [NP];
    logic [2:0]           ptr_q   [NP];

    logic [2:0]           route   [NP];
    logic [NP-1:0]        in_busy;
    logic [NP-1:0]        cand    [NP];
    logic [NP-1:0]        grant_v;
    logic [2:0]           grant_idx [NP];
    logic [NP-1:0]        xfer;

    // Destination port for a head address field; dimension order picked by ROUTING_MODE.
    function automatic logic [2:0] route_of(input logic [XW+YW-1:0] addr);
        int         dx;
        int         dy;
        logic [2:0] px;
        logic [2:0] py;
        dx = int'(addr[XW-1:0]);
        dy = int'(addr[XW+YW-1:XW]);
        px = (dx > ROUTER_X) ? P_EAST  : (dx < ROUTER_X) ? P_WEST  : P_LOCAL;
        py = (dy > ROUTER_Y) ? P_SOUTH : (dy < ROUTER_Y) ? P_NORTH : P_LOCAL;
        if (ROUTING_MODE == 0) route_of = (px != P_LOCAL) ? px : py;
        else                   route_of = (py != P_LOCAL) ? py : px;
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CW'(BUF_DEPTH));
            front[i] = mem_q[i][rd_q[i]];
        end
    end

    // No bypass: acceptance depends on occupancy only, never on a same-cycle pop.
    assign in_ack = ~full;
    assign push   = in_req & ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_q[i]] <= in_data[i*FLIT_SIZE +: FLIT_SIZE];
                    wr_q[i]           <= wr_q[i] + 1'b1;
                end
                if (pop[i]) rd_q[i] <= rd_q[i] + 1'b1;
                if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            route[i]   = route_of(front[i][XW+YW-1:0]);
            in_busy[i] = 1'b0;
            for (int o = 0; o < NP; o++) begin
                if (lock_q[o] && (owner_q[o] == 3'(i))) in_busy[i] = 1'b1;
            end
        end
        // Type bit FLIT_SIZE-2 is set for head (01) and single (11) flits.
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                cand[o][i] = !empty[i] && front[i][FLIT_SIZE-2] && !in_busy[i]
                             && (route[i] == 3'(o));
            end
        end
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NP; o++) begin
            grant_v[o]   = 1'b0;
            grant_idx[o] = '0;
            for (int k = 0; k < NP; k++) begin
                idx = int'(ptr_q[o]) + k;
                if (idx >= NP) idx = idx - NP;
                if (!lock_q[o] && !grant_v[o] && cand[o][idx]) begin
                    grant_v[o]   = 1'b1;
                    grant_idx[o] = 3'(idx);
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            out_data[o*FLIT_SIZE +: FLIT_SIZE] = lock_q[o] ? front[owner_q[o]] : '0;
            out_req[o] = lock_q[o] && !empty[owner_q[o]];
            xfer[o]    = out_req[o] && out_ack[o];
            if (xfer[o]) pop[owner_q[o]] = 1'b1;
        end
    end

    assign out_busy = lock_q;

    // Type bit FLIT_SIZE-1 marks tail (10) and single (11): the packet's last flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NP; o++) begin
                lock_q[o]  <= 1'b0;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (lock_q[o]) begin
                    if (xfer[o] && front[owner_q[o]][FLIT_SIZE-1]) lock_q[o] <= 1'b0;
                end else if (grant_v[o]) begin
                    lock_q[o]  <= 1'b1;
                    owner_q[o] <= grant_idx[o];
                    ptr_q[o]   <= (grant_idx[o] == 3'(NP-1)) ? 3'd0 : grant_idx[o] + 3'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wormhole_mesh_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_wormhole_mesh_router
// Brief   : Bench for router (1,1) in a 4x4 mesh, XY instance plus a YX instance.
// Revision: 1.0
// ============================================================================
module tb_wormhole_mesh_router;
    localparam int FS   = 18;
    localparam int NP   = 5;
    localparam int NPKT = 60;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic [NP*FS-1:0] in_data = '0;
    logic [NP-1:0]    in_req  = '0;
    logic [NP-1:0]    out_ack = '1;
    logic [NP-1:0]    in_ack_a, out_req_a, out_busy_a;
    logic [NP-1:0]    in_ack_b, out_req_b, out_busy_b;
    logic [NP*FS-1:0] out_data_a, out_data_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_mode = 1'b0;

    logic [FS-1:0] src_q [NP][$];
    logic [FS-1:0] cap_q [NP][$];

    typedef struct {
        bit mode;
        int port;
        int dx;
        int dy;
        int eo;
    } vec_t;
    vec_t vt [12];

    int            pkt_src  [NPKT];
    int            pkt_out  [NPKT];
    int            pkt_len  [NPKT];
    logic [FS-1:0] pkt_flit [NPKT][4];

    always #5 clk = ~clk;

    wormhole_mesh_router #(
        .FLIT_SIZE(FS), .BUF_DEPTH(4), .NOC_WIDTH(4), .NOC_LENGTH(4),
        .ROUTER_X(1), .ROUTER_Y(1), .ROUTING_MODE(0)
    ) u_xy (
        .clk(clk), .rst(rst), .in_data(in_data), .in_req(in_req), .in_ack(in_ack_a),
        .out_data(out_data_a), .out_req(out_req_a), .out_ack(out_ack), .out_busy(out_busy_a)
    );

    wormhole_mesh_router #(
        .FLIT_SIZE(FS), .BUF_DEPTH(4), .NOC_WIDTH(4), .NOC_LENGTH(4),
        .ROUTER_X(1), .ROUTER_Y(1), .ROUTING_MODE(1)
    ) u_yx (
        .clk(clk), .rst(rst), .in_data(in_data), .in_req(in_req), .in_ack(in_ack_b),
        .out_data(out_data_b), .out_req(out_req_b), .out_ack(out_ack), .out_busy(out_busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input int dx, input int dy, input int pl);
        logic [FS-1:0] f;
        f = {t, pl[11:0], dy[1:0], dx[1:0]};
        return f;
    endfunction

    // Reference route for router (1,1): resolve one dimension fully, then the other.
    function automatic int ref_route(input int dx, input int dy, input int mode);
        int ex;
        int ey;
        ex = (dx > 1) ? 3 : (dx < 1) ? 1 : 0;
        ey = (dy > 1) ? 4 : (dy < 1) ? 2 : 0;
        if (mode == 0) return (ex != 0) ? ex : ey;
        return (ey != 0) ? ey : ex;
    endfunction

    task automatic drive(input logic [NP-1:0] taken);
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() == 0) in_req[i] = 1'b0;
            else if (!(in_req[i] && !taken[i]))
                in_req[i] = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data[i*FS +: FS] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    // Record the handshakes that complete on the coming edge, advance, then re-drive.
    task automatic tick();
        logic [NP-1:0] taken;
        taken = in_req & in_ack_a;
        for (int i = 0; i < NP; i++) if (taken[i]) void'(src_q[i].pop_front());
        for (int o = 0; o < NP; o++)
            if (out_req_a[o] && out_ack[o]) cap_q[o].push_back(out_data_a[o*FS +: FS]);
        @(posedge clk);
        #1;
        if (rnd_mode) out_ack = NP'($urandom_range(0, 31));
        drive(taken);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            cap_q[i].delete();
        end
        in_req = '0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_single(input string nm, input bit mode, input int port,
                              input int dx, input int dy, input int eo);
        logic [FS-1:0] f;
        f = mk(2'b11, dx, dy, int'($urandom_range(0, 4095)));
        src_q[port].push_back(f);
        drive('0);
        tick();
        chk({nm, " out_req in alloc cycle"}, mode ? out_req_b : out_req_a, 0);
        tick();
        chk({nm, " out_req"}, mode ? out_req_b : out_req_a, 1 << eo);
        chk({nm, " out_busy"}, mode ? out_busy_b : out_busy_a, 1 << eo);
        chk({nm, " out_data"}, mode ? out_data_b[eo*FS +: FS] : out_data_a[eo*FS +: FS], f);
        tick();
        chk({nm, " out_busy after tail"}, mode ? out_busy_b : out_busy_a, 0);
        chk({nm, " in_ack after drain"}, mode ? in_ack_b : in_ack_a, 5'h1F);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FS-1:0] f;
        logic [FS-1:0] pk [6];
        logic [FS-1:0] exp_seq [7];
        bit            exp_v [7];
        int            total;
        int            ncap;
        int            cyc;
        int            seen;
        int            last_id [NP][NP];

        vt[0]  = '{0, 0, 3, 1, 3};
        vt[1]  = '{0, 1, 1, 3, 4};
        vt[2]  = '{0, 3, 0, 2, 1};
        vt[3]  = '{0, 4, 1, 0, 2};
        vt[4]  = '{0, 0, 1, 1, 0};
        vt[5]  = '{0, 2, 2, 0, 3};
        vt[6]  = '{0, 1, 0, 0, 1};
        vt[7]  = '{0, 2, 1, 2, 4};
        vt[8]  = '{1, 1, 2, 0, 2};
        vt[9]  = '{1, 0, 0, 2, 4};
        vt[10] = '{1, 3, 1, 1, 0};
        vt[11] = '{1, 0, 3, 1, 3};

        // Reset state and idle after release.
        tick();
        tick();
        chk("reset out_req", out_req_a, 0);
        chk("reset out_busy", out_busy_a, 0);
        chk("reset in_ack", in_ack_a, 5'h1F);
        chk("reset out_data zero", out_data_a == '0, 1);
        rst = 1'b0;
        tick();
        chk("post-reset out_req", out_req_a, 0);
        chk("post-reset in_ack", in_ack_a, 5'h1F);

        for (int v = 0; v < 12; v++)
            run_single($sformatf("vec%0d", v), vt[v].mode, vt[v].port, vt[v].dx, vt[v].dy, vt[v].eo);

        // West head/body/tail to (1,3) leaves south on consecutive cycles.
        pk[0] = mk(2'b01, 1, 3, 12'h111);
        pk[1] = mk(2'b00, 1, 3, 12'h222);
        pk[2] = mk(2'b10, 1, 3, 12'h333);
        for (int k = 0; k < 3; k++) src_q[1].push_back(pk[k]);
        drive('0);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hbt south req %0d", k), out_req_a[4], 1);
            chk($sformatf("hbt south data %0d", k), out_data_a[4*FS +: FS], pk[k]);
            tick();
        end
        chk("hbt south busy cleared", out_busy_a[4], 0);

        // Local and west contend for east from ptr 0.
        do_reset();
        exp_seq[0] = mk(2'b01, 3, 1, 12'hA01);
        exp_seq[1] = mk(2'b00, 3, 1, 12'hA02);
        exp_seq[2] = mk(2'b10, 3, 1, 12'hA03);
        exp_seq[3] = '0;
        exp_seq[4] = mk(2'b01, 3, 1, 12'hB01);
        exp_seq[5] = mk(2'b00, 3, 1, 12'hB02);
        exp_seq[6] = mk(2'b10, 3, 1, 12'hB03);
        exp_v = '{1, 1, 1, 0, 1, 1, 1};
        for (int k = 0; k < 3; k++) begin
            src_q[0].push_back(exp_seq[k]);
            src_q[1].push_back(exp_seq[k+4]);
        end
        drive('0);
        tick();
        tick();
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("rr east req cycle %0d", k), out_req_a[3], exp_v[k]);
            if (exp_v[k]) chk($sformatf("rr east data cycle %0d", k), out_data_a[3*FS +: FS], exp_seq[k]);
            tick();
        end
        chk("rr east busy cleared", out_busy_a[3], 0);
        // Pointer now at 2: south input wins over west.
        pk[0] = mk(2'b11, 3, 1, 12'hC01);
        pk[1] = mk(2'b11, 3, 1, 12'hC04);
        src_q[1].push_back(pk[0]);
        src_q[4].push_back(pk[1]);
        drive('0);
        tick();
        tick();
        chk("ptr2 first winner south", out_data_a[3*FS +: FS], pk[1]);
        tick();
        chk("ptr2 idle gap", out_req_a[3], 0);
        tick();
        chk("ptr2 second winner west", out_data_a[3*FS +: FS], pk[0]);
        tick();

        // Backpressure: east stalled, local FIFO fills after 4 flits.
        out_ack = 5'b10111;
        pk[0] = mk(2'b01, 3, 1, 12'hD00);
        for (int k = 1; k < 5; k++) pk[k] = mk(2'b00, 3, 1, 12'hD00 + k);
        pk[5] = mk(2'b10, 3, 1, 12'hD05);
        for (int k = 0; k < 6; k++) src_q[0].push_back(pk[k]);
        drive('0);
        for (int k = 0; k < 4; k++) tick();
        chk("bp in_ack low when full", in_ack_a[0], 0);
        chk("bp flits left at source", src_q[0].size(), 2);
        chk("bp out_req held", out_req_a[3], 1);
        chk("bp head held", out_data_a[3*FS +: FS], pk[0]);
        tick();
        tick();
        chk("bp in_ack still low", in_ack_a[0], 0);
        out_ack = '1;
        cap_q[3].delete();
        cyc = 0;
        while (cap_q[3].size() < 6 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp drained count", cap_q[3].size(), 6);
        for (int k = 0; k < 6 && k < cap_q[3].size(); k++)
            chk($sformatf("bp order %0d", k), cap_q[3][k], pk[k]);
        chk("bp in_ack recovered", in_ack_a, 5'h1F);
        chk("bp busy cleared", out_busy_a[3], 0);

        // Reset with a packet in flight.
        src_q[0].push_back(mk(2'b01, 3, 1, 12'hE01));
        src_q[0].push_back(mk(2'b00, 3, 1, 12'hE02));
        drive('0);
        tick();
        tick();
        tick();
        chk("midpkt busy before reset", out_busy_a[3], 1);
        for (int i = 0; i < NP; i++) src_q[i].delete();
        in_req = '0;
        rst    = 1'b1;
        tick();
        chk("midpkt reset out_req", out_req_a, 0);
        chk("midpkt reset out_busy", out_busy_a, 0);
        chk("midpkt reset in_ack", in_ack_a, 5'h1F);
        rst = 1'b0;
        run_single("after midpkt reset", 0, 0, 3, 1, 3);

        // Randomized traffic against the packet-level model.
        do_reset();
        total = 0;
        for (int id = 0; id < NPKT; id++) begin
            int dx;
            int dy;
            logic [1:0] t;
            pkt_src[id] = int'($urandom_range(0, 4));
            dx          = int'($urandom_range(0, 3));
            dy          = int'($urandom_range(0, 3));
            pkt_len[id] = int'($urandom_range(1, 4));
            pkt_out[id] = ref_route(dx, dy, 0);
            for (int k = 0; k < pkt_len[id]; k++) begin
                if (pkt_len[id] == 1)          t = 2'b11;
                else if (k == 0)               t = 2'b01;
                else if (k == pkt_len[id] - 1) t = 2'b10;
                else                           t = 2'b00;
                f = mk(t, dx, dy, (id << 4) | k);
                pkt_flit[id][k] = f;
                src_q[pkt_src[id]].push_back(f);
                total++;
            end
        end
        rnd_mode = 1'b1;
        drive('0);
        ncap = 0;
        cyc  = 0;
        while (ncap < total && cyc < 5000) begin
            tick();
            cyc++;
            ncap = 0;
            for (int o = 0; o < NP; o++) ncap += cap_q[o].size();
        end
        rnd_mode = 1'b0;
        out_ack  = '1;
        chk("rand flits delivered", ncap, total);
        for (int s = 0; s < NP; s++) for (int o = 0; o < NP; o++) last_id[s][o] = -1;
        seen = 0;
        for (int o = 0; o < NP; o++) begin
            int idx;
            idx = 0;
            while (idx < cap_q[o].size()) begin
                int id;
                f  = cap_q[o][idx];
                id = int'(f[15:8]);
                chk($sformatf("rand out%0d packet starts with head", o), f[FS-2], 1);
                chk($sformatf("rand out%0d id in range", o), id < NPKT, 1);
                if (id >= NPKT) break;
                chk($sformatf("rand pkt%0d output port", id), o, pkt_out[id]);
                chk($sformatf("rand pkt%0d source order", id), id > last_id[pkt_src[id]][o], 1);
                last_id[pkt_src[id]][o] = id;
                for (int k = 0; k < pkt_len[id]; k++) begin
                    if (idx + k < cap_q[o].size())
                        chk($sformatf("rand pkt%0d flit%0d", id, k), cap_q[o][idx+k], pkt_flit[id][k]);
                    else
                        chk($sformatf("rand pkt%0d flit%0d present", id, k), 0, 1);
                end
                seen++;
                idx += pkt_len[id];
            end
        end
        chk("rand packets seen", seen, NPKT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
